// File: rtl/desc_chain_ctrl.sv
// Descriptor-chain controller: fetches batches of job descriptors over a 64-bit Wishbone
// master, loads them into NSLOT engine slots, retires each slot and follows the chain.
module desc_chain_ctrl #(
    parameter int NSLOT      = 2,
    parameter int DESC_BEATS = 4,
    parameter int RTY_MAX    = 3
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_n,
    input  logic                          enable,
    input  logic                          start,
    input  logic [28:0]                   start_adr,
    output logic                          wbm_cyc_o,
    output logic                          wbm_stb_o,
    output logic                          wbm_we_o,
    output logic [31:0]                   wbm_adr_o,
    output logic [63:0]                   wbm_dat_o,
    input  logic [63:0]                   wbm_dat_i,
    input  logic                          wbm_ack_i,
    input  logic                          wbm_err_i,
    input  logic                          wbm_rty_i,
    output logic [NSLOT-1:0]              ss_we,
    output logic [$clog2(DESC_BEATS)-1:0] ss_adr,
    output logic [63:0]                   ss_dat,
    output logic [NSLOT*24-1:0]           ss_dc,
    output logic [NSLOT-1:0]              ss_done,
    output logic [NSLOT-1:0]              m_reset,
    input  logic [NSLOT-1:0]              c_done,
    output logic [31:0]                   dar,
    output logic                          busy,
    output logic                          err_o,
    output logic                          int_o,
    input  logic                          int_clear
);

    // state    | meaning
    // S_IDLE   | waiting for start
    // S_FETCH  | reading descriptor beats into slot k
    // S_DECODE | decide: fetch next descriptor into this batch or start serving slots
    // S_WAIT   | waiting for c_done of slot i
    // S_CTL    | single-beat status writeback for slot i
    // S_DONE   | retire slot i, then next slot / next batch / idle
    // S_ERR    | bus error, held until enable drops

    localparam int BW = $clog2(DESC_BEATS);
    localparam int KW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam int RW = (RTY_MAX > 0) ? $clog2(RTY_MAX + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_WAIT, S_CTL, S_DONE, S_ERR
    } state_t;

    state_t                 state;
    logic [28:0]            adr_q;
    logic [28:0]            base_q;
    logic [BW-1:0]          beat_q;
    logic [KW-1:0]          k_q;
    logic [KW-1:0]          i_q;
    logic [KW:0]            nslots_q;
    logic [KW:0]            i_nxt;
    logic [RW-1:0]          rty_cnt;
    logic [NSLOT-1:0][28:0] next_q;
    logic [NSLOT-1:0][28:0] ctl_q;
    logic [NSLOT-1:0][28:0] desc_q;
    logic [NSLOT-1:0][23:0] dc_q;
    logic                   fetch_ack;
    logic                   bus_abort;

    assign fetch_ack = (state == S_FETCH) && wbm_cyc_o && wbm_ack_i && !wbm_err_i && !wbm_rty_i;
    assign bus_abort = (state inside {S_FETCH, S_CTL}) && wbm_cyc_o && (wbm_err_i || wbm_rty_i);
    assign i_nxt     = {1'b0, i_q} + (KW+1)'(1);

    assign ss_we     = fetch_ack ? (NSLOT'(1) << k_q) : '0;
    assign ss_adr    = fetch_ack ? beat_q : '0;
    assign ss_dat    = wbm_dat_i;
    assign ss_dc     = dc_q;
    assign wbm_adr_o = {adr_q, 3'b000};
    assign busy      = (state != S_IDLE) && (state != S_ERR);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= S_IDLE;
            adr_q     <= '0;
            base_q    <= '0;
            beat_q    <= '0;
            k_q       <= '0;
            i_q       <= '0;
            nslots_q  <= '0;
            rty_cnt   <= '0;
            next_q    <= '0;
            ctl_q     <= '0;
            desc_q    <= '0;
            dc_q      <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_dat_o <= '0;
            ss_done   <= '0;
            m_reset   <= '1;
            dar       <= '0;
            err_o     <= 1'b0;
            int_o     <= 1'b0;
        end else begin
            ss_done <= '0;
            m_reset <= ss_done;
            if (int_clear)
                int_o <= 1'b0;

            if (bus_abort) begin
                // a retried burst restarts from its first beat after one idle cycle
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                wbm_we_o  <= 1'b0;
                if (wbm_err_i || rty_cnt == RW'(RTY_MAX)) begin
                    state <= S_ERR;
                    err_o <= 1'b1;
                end else begin
                    rty_cnt <= rty_cnt + RW'(1);
                    adr_q   <= base_q;
                    beat_q  <= '0;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && enable) begin
                            adr_q   <= start_adr;
                            base_q  <= start_adr;
                            k_q     <= '0;
                            beat_q  <= '0;
                            rty_cnt <= '0;
                            state   <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (!wbm_cyc_o) begin
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                        end else if (wbm_ack_i) begin
                            if (beat_q == '0) begin
                                next_q[k_q] <= wbm_dat_i[63:35];
                                ctl_q[k_q]  <= wbm_dat_i[31:3];
                                desc_q[k_q] <= base_q;
                            end
                            if (beat_q == BW'(1))
                                dc_q[k_q] <= wbm_dat_i[55:32];
                            adr_q  <= adr_q + 29'd1;
                            beat_q <= beat_q + BW'(1);
                            if (beat_q == BW'(DESC_BEATS - 1)) begin
                                wbm_cyc_o <= 1'b0;
                                wbm_stb_o <= 1'b0;
                                rty_cnt   <= '0;
                                state     <= S_DECODE;
                            end
                        end
                    end
                    S_DECODE: begin
                        if (dc_q[k_q][14] && k_q != KW'(NSLOT - 1)) begin
                            k_q    <= k_q + KW'(1);
                            adr_q  <= next_q[k_q];
                            base_q <= next_q[k_q];
                            beat_q <= '0;
                            state  <= S_FETCH;
                        end else begin
                            nslots_q <= {1'b0, k_q} + (KW+1)'(1);
                            i_q      <= '0;
                            state    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (!enable) begin
                            m_reset <= '1;
                            state   <= S_IDLE;
                        end else if (c_done[i_q]) begin
                            if (dc_q[i_q][7]) begin
                                adr_q     <= ctl_q[i_q];
                                base_q    <= ctl_q[i_q];
                                wbm_dat_o <= {8'h00, dc_q[i_q], 32'h0000_0001};
                                state     <= S_CTL;
                            end else begin
                                state <= S_DONE;
                            end
                        end
                    end
                    S_CTL: begin
                        if (!wbm_cyc_o) begin
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_we_o  <= 1'b1;
                        end else if (wbm_ack_i) begin
                            wbm_cyc_o <= 1'b0;
                            wbm_stb_o <= 1'b0;
                            wbm_we_o  <= 1'b0;
                            rty_cnt   <= '0;
                            state     <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        ss_done[i_q] <= 1'b1;
                        dar          <= {desc_q[i_q], 3'b000};
                        if (dc_q[i_q][15])
                            int_o <= 1'b1;
                        if (!enable) begin
                            m_reset <= '1;
                            state   <= S_IDLE;
                        end else if (i_nxt < nslots_q) begin
                            i_q   <= i_q + KW'(1);
                            state <= S_WAIT;
                        end else if (dc_q[i_q][14]) begin
                            adr_q  <= next_q[i_q];
                            base_q <= next_q[i_q];
                            k_q    <= '0;
                            beat_q <= '0;
                            state  <= S_FETCH;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_ERR: begin
                        if (!enable) begin
                            err_o <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
